// File: rtl/fifo_uart_pkg.sv
// Shared FSM encoding and frame constants for the FIFO-fed 8N1 transmitter.
// Pure declarations: no latency, no backpressure.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/baud_counter.sv
// Bit-period divider: tick pulses on the last clock of every CLKS_PER_BIT-cycle bit.
// Tick is combinational from the count register; clr forces and holds the count at zero.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO byte per frame and serialises it as 8N1 on TX; READ to TX-low is 2 cycles.
// Backpressure: a frame starts only when ENABLE and F_EMPTY_N are high in IDLE.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              F_EMPTY_N,
    input  logic [DATA_W-1:0] FIFO_DATA,
    output logic              READ,
    output logic              TX,
    output logic              BUSY,
    output logic              TX_DONE
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic [BW-1:0]     bit_cnt;
    logic              baud_clr;
    logic              tick;

    // Baud count sits at zero outside the serial states, so START always gets a full bit.
    assign baud_clr  = (state == IDLE) || (state == POP) || (state == LATCH);
    assign shift_nxt = shift >> 1;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            TX      <= 1'b1;
            READ    <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            READ <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE && F_EMPTY_N) begin
                        state <= POP;
                        READ  <= 1'b1;
                    end
                end
                POP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shift <= FIFO_DATA;
                    TX    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        TX      <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            TX    <= 1'b1;
                        end else begin
                            shift   <= shift_nxt;
                            TX      <= shift_nxt[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

    assign BUSY    = (state != IDLE);
    assign TX_DONE = (state == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-based FIFO model and a mid-bit TX sampler.
module tb_fifo_uart_tx;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b1;
    logic       F_EMPTY_N = 1'b0;
    logic [7:0] FIFO_DATA = 8'h00;
    logic       READ;
    logic       TX;
    logic       BUSY;
    logic       TX_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];
    int         pop_empty = 0;

    int  cyc = 0;
    int  read_cnt = 0;
    int  done_cnt = 0;
    int  read_double = 0;
    int  last_done_cyc = 0;
    int  read_times[$];
    logic prev_read = 1'b0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(16),
        .DATA_W      (8)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .F_EMPTY_N(F_EMPTY_N),
        .FIFO_DATA(FIFO_DATA),
        .READ     (READ),
        .TX       (TX),
        .BUSY     (BUSY),
        .TX_DONE  (TX_DONE)
    );

    always #10 CLOCK = ~CLOCK;

    // FIFO model: pop on a sampled READ, data valid the following cycle.
    always @(posedge CLOCK) begin
        if (READ) begin
            if (fifo_q.size() == 0) pop_empty++;
            else FIFO_DATA <= fifo_q.pop_front();
        end
    end

    always @(negedge CLOCK) begin
        F_EMPTY_N <= (fifo_q.size() != 0);
    end

    always @(negedge CLOCK) begin
        cyc++;
        if (READ) begin
            read_cnt++;
            read_times.push_back(cyc);
            if (prev_read) read_double++;
        end
        if (TX_DONE) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        prev_read = READ;
    end

    // Waits for a start bit and samples all 10 bits mid-bit; bits[0] is the start bit.
    task automatic capture_frame(output logic [9:0] bits);
        int k = 0;
        do begin
            @(negedge CLOCK);
            k++;
        end while (TX !== 1'b0 && k < 2000);
        if (TX !== 1'b0) begin
            bits = 10'bx;
            $display("FAIL capture_frame: no start bit within %0d cycles", k);
            return;
        end
        repeat (7) @(negedge CLOCK);
        for (int b = 0; b < 10; b++) begin
            bits[b] = TX;
            if (b < 9) repeat (16) @(negedge CLOCK);
        end
    endtask

    task automatic wait_read(output bit seen);
        int k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge CLOCK);
            k++;
            if (READ === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        #1 RESET = 1'b1;
        repeat (50) begin
            @(negedge CLOCK);
            if (TX !== 1'b1 || READ !== 1'b0 || BUSY !== 1'b0 || TX_DONE !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_hold: bad cycles %0d, want 0", bad); end
        RESET = 1'b0;
        repeat (10) @(negedge CLOCK);
        n_checks++;
        if (read_cnt !== 0) begin n_fail++; $display("FAIL empty_no_read: reads %0d, want 0", read_cnt); end
        n_checks++;
        if (TX !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL empty_idle: TX %b BUSY %b, want 1 0", TX, BUSY); end
    endtask

    task automatic test_single;
        logic [9:0] bits;
        bit seen;
        int r0 = read_cnt;
        int d0 = done_cnt;
        fifo_q.push_back(8'hA5);
        wait_read(seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL single_read: READ not seen, want pulse"); end
        @(negedge CLOCK);
        n_checks++;
        if (READ !== 1'b0 || TX !== 1'b1) begin n_fail++; $display("FAIL single_latch: READ %b TX %b, want 0 1", READ, TX); end
        @(negedge CLOCK);
        n_checks++;
        if (TX !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL single_start: TX %b BUSY %b, want 0 1", TX, BUSY); end
        repeat (7) @(negedge CLOCK);
        for (int b = 0; b < 10; b++) begin
            bits[b] = TX;
            if (b < 9) repeat (16) @(negedge CLOCK);
        end
        n_checks++;
        if (bits !== 10'b1101001010) begin n_fail++; $display("FAIL single_frame: got %b, want 1101001010", bits); end
        n_checks++;
        if (bits[8:1] !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %h, want a5", bits[8:1]); end
        repeat (20) @(negedge CLOCK);
        n_checks++;
        if (done_cnt - d0 !== 1 || read_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL single_counts: done %0d read %0d, want 1 1", done_cnt - d0, read_cnt - r0);
        end
        n_checks++;
        if (last_done_cyc - read_times[read_times.size()-1] !== 161) begin
            n_fail++; $display("FAIL single_done_time: %0d, want 161", last_done_cyc - read_times[read_times.size()-1]);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits;
        logic [7:0] exp_b[3] = '{8'h01, 8'h80, 8'hFF};
        int r0 = read_cnt;
        int n;
        for (int i = 0; i < 3; i++) fifo_q.push_back(exp_b[i]);
        for (int i = 0; i < 3; i++) begin
            capture_frame(bits);
            n_checks++;
            if (bits !== {1'b1, exp_b[i], 1'b0}) begin
                n_fail++; $display("FAIL b2b_frame%0d: got %b, want %b", i, bits, {1'b1, exp_b[i], 1'b0});
            end
        end
        repeat (30) @(negedge CLOCK);
        n = read_times.size();
        n_checks++;
        if (read_cnt - r0 !== 3) begin n_fail++; $display("FAIL b2b_reads: %0d, want 3", read_cnt - r0); end
        n_checks++;
        if (read_times[n-1] - read_times[n-2] !== 163 || read_times[n-2] - read_times[n-3] !== 163) begin
            n_fail++; $display("FAIL b2b_spacing: %0d %0d, want 163 163",
                               read_times[n-2] - read_times[n-3], read_times[n-1] - read_times[n-2]);
        end
        n_checks++;
        if (F_EMPTY_N !== 1'b0 || BUSY !== 1'b0 || TX !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle: F_EMPTY_N %b BUSY %b TX %b, want 0 0 1", F_EMPTY_N, BUSY, TX);
        end
    endtask

    task automatic test_enable_drop;
        logic [9:0] bits;
        bit seen;
        int r0 = read_cnt;
        int d0 = done_cnt;
        fifo_q.push_back(8'h66);
        fifo_q.push_back(8'h99);
        wait_read(seen);
        @(negedge CLOCK);
        ENABLE = 1'b0;
        capture_frame(bits);
        n_checks++;
        if (bits !== {1'b1, 8'h66, 1'b0}) begin n_fail++; $display("FAIL en_frame1: got %b, want %b", bits, {1'b1, 8'h66, 1'b0}); end
        repeat (40) @(negedge CLOCK);
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL en_done: %0d, want 1", done_cnt - d0); end
        repeat (200) @(negedge CLOCK);
        n_checks++;
        if (read_cnt - r0 !== 1 || BUSY !== 1'b0 || TX !== 1'b1) begin
            n_fail++; $display("FAIL en_hold: reads %0d BUSY %b TX %b, want 1 0 1", read_cnt - r0, BUSY, TX);
        end
        ENABLE = 1'b1;
        capture_frame(bits);
        n_checks++;
        if (bits !== {1'b1, 8'h99, 1'b0}) begin n_fail++; $display("FAIL en_frame2: got %b, want %b", bits, {1'b1, 8'h99, 1'b0}); end
        repeat (30) @(negedge CLOCK);
        n_checks++;
        if (read_cnt - r0 !== 2) begin n_fail++; $display("FAIL en_reads: %0d, want 2", read_cnt - r0); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits;
        bit seen;
        int r0 = read_cnt;
        fifo_q.push_back(8'hC3);
        fifo_q.push_back(8'h5A);
        wait_read(seen);
        repeat (73) @(negedge CLOCK);
        n_checks++;
        if (TX !== 1'b0) begin n_fail++; $display("FAIL rst_bit3: TX %b, want 0", TX); end
        RESET = 1'b1;
        #1;
        n_checks++;
        if (TX !== 1'b1 || BUSY !== 1'b0 || READ !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: TX %b BUSY %b READ %b, want 1 0 0", TX, BUSY, READ);
        end
        @(negedge CLOCK);
        RESET = 1'b0;
        capture_frame(bits);
        n_checks++;
        if (bits !== {1'b1, 8'h5A, 1'b0}) begin n_fail++; $display("FAIL rst_next: got %b, want %b", bits, {1'b1, 8'h5A, 1'b0}); end
        repeat (30) @(negedge CLOCK);
        n_checks++;
        if (read_cnt - r0 !== 2) begin n_fail++; $display("FAIL rst_reads: %0d, want 2", read_cnt - r0); end
    endtask

    task automatic test_full;
        logic [9:0] bits;
        logic [7:0] v;
        int r0 = read_cnt;
        ENABLE = 1'b0;
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'(i * 37 + 5));
        repeat (2) @(negedge CLOCK);
        n_checks++;
        if (fifo_q.size() !== 32 || F_EMPTY_N !== 1'b1) begin
            n_fail++; $display("FAIL full_fill: size %0d F_EMPTY_N %b, want 32 1", fifo_q.size(), F_EMPTY_N);
        end
        ENABLE = 1'b1;
        for (int i = 0; i < 32; i++) begin
            v = 8'(i * 37 + 5);
            capture_frame(bits);
            n_checks++;
            if (bits !== {1'b1, v, 1'b0}) begin n_fail++; $display("FAIL full_frame%0d: got %b, want %b", i, bits, {1'b1, v, 1'b0}); end
        end
        repeat (200) @(negedge CLOCK);
        n_checks++;
        if (read_cnt - r0 !== 32 || fifo_q.size() !== 0) begin
            n_fail++; $display("FAIL full_drain: reads %0d left %0d, want 32 0", read_cnt - r0, fifo_q.size());
        end
        n_checks++;
        if (pop_empty !== 0 || read_double !== 0) begin
            n_fail++; $display("FAIL full_pops: empty pops %0d long reads %0d, want 0 0", pop_empty, read_double);
        end
        n_checks++;
        if (BUSY !== 1'b0 || TX !== 1'b1) begin n_fail++; $display("FAIL full_idle: BUSY %b TX %b, want 0 1", BUSY, TX); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_enable_drop;
        test_reset_mid;
        test_full;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 32-deep byte FIFO: drains it one word at a time and sends each byte as an 8N1 asynchronous serial frame on TX.
- Drives the FIFO's READ strobe and samples its DATA_OUT and F_EMPTY_N.
- Sits between the FIFO and the board serial pin, in the same CLOCK domain as the FIFO.

Parameters:
CLKS_PER_BIT, 16, CLOCK cycles per serial bit; legal range >= 2.
DATA_W, 8, frame data width; must match FIFO width.

Ports:
CLOCK  in  1  system clock; all logic on rising edge.
RESET  in  1  asynchronous, active-high reset.
ENABLE  in  1  permits starting a new frame; sampled only in IDLE.
F_EMPTY_N  in  1  FIFO not-empty flag (1 = data available).
FIFO_DATA  in  DATA_W  FIFO DATA_OUT; valid the cycle after READ is sampled high.
READ  out  1  one-cycle FIFO pop strobe.
TX  out  1  serial line; idle high.
BUSY  out  1  high in every state except IDLE.
TX_DONE  out  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - RESET forces state=IDLE, TX=1, READ=0, BUSY=0, TX_DONE=0, bit/baud counters=0, shift register=0.
  - All of these hold while RESET=1.
  - Reset mid-frame aborts the frame immediately; TX returns high with no glitch low.
  - A byte already popped from the FIFO is lost; this is accepted.
- State machine (registered; outputs decoded from registered state and counters):
  - IDLE: TX=1.
    - If ENABLE=1 and F_EMPTY_N=1 at a rising edge, go to POP; otherwise stay.
  - POP: READ=1 for exactly this one cycle. Unconditionally go to LATCH.
  - LATCH: FIFO_DATA is valid; shift register <= FIFO_DATA at the closing edge. Go to START.
  - START: TX=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: TX = shift[0], LSB first, each bit held CLKS_PER_BIT cycles.
    - Shift right after each bit.
    - After bit DATA_W-1, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles.
    - TX_DONE=1 in the final cycle.
    - Go to IDLE.
- Timing:
  - Pop-to-TX-falling latency: F_EMPTY_N seen high in IDLE at edge t0 gives READ high during (t0, t0+1] and TX low from edge t0+2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frame spacing is 10*CLKS_PER_BIT+3 cycles (IDLE, POP, LATCH overhead).
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0, and clears on every state change.
  - Bit counter is $clog2(DATA_W) bits and clears entering DATA.
- Boundary conditions:
  - FIFO empty: never assert READ; stay in IDLE with TX=1.
  - F_EMPTY_N dropping after POP does not cancel the frame.
  - ENABLE deasserted mid-frame: the current frame completes; no new pop follows.
  - Only one READ per frame, so the FIFO is never popped while empty, provided F_EMPTY_N is correct at the IDLE decision.
  - Upstream writes concurrent with READ are the FIFO's concern; this block ignores WRITE.

Decomposition:
- Package fifo_uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, POP, LATCH, START, DATA, STOP}.
  - Constants STOP_BITS=1 and FRAME_BITS=10.
- One sub-module, baud_counter: parameter CLKS_PER_BIT; inputs CLOCK, RESET, clr; output tick, a one-cycle pulse on the last cycle of each bit.

Test Plan (T=20 ns, CLKS_PER_BIT=16, bit time 320 ns):
- Reset with F_EMPTY_N=0, ENABLE=1 for 50 cycles -> TX=1, READ=0, BUSY=0 throughout.
- FIFO holds 8'hA5; raise F_EMPTY_N -> READ high for exactly 1 cycle; TX low 2 cycles after the decision edge; TX sequence 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB first, stop), each bit 16 cycles; TX_DONE one pulse; decoded byte is 8'hA5.
- FIFO loaded with 3 bytes 8'h01, 8'h80, 8'hFF -> exactly 3 READ pulses spaced 163 cycles apart; decoded bytes 01, 80, FF in order; then idle with F_EMPTY_N=0.
- Fill the FIFO to 32 entries (F_FULL_N=0 at the FIFO), then enable -> 32 frames, 32 READ pulses, FIFO USE_DW reaches 0, no READ issued while F_EMPTY_N=0.
- Assert RESET for 1 cycle in the middle of DATA bit 3 -> TX=1 and BUSY=0 within the same cycle; the next frame begins cleanly with the following FIFO byte.
- ENABLE=0 during frame 1 of 2 queued -> frame 1 completes with TX_DONE; no second READ until ENABLE returns to 1.
